// File: rtl/adder_arbiter_if.sv
// Handshake bundle between three requesters, the shared adder and the consumer.
// slave is the arbiter's view; master is the environment's view.
interface adder_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [2:0]         req_valid;
    logic [3*WIDTH-1:0] req_x;
    logic [3*WIDTH-1:0] req_y;
    logic [2:0]         req_ready;
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic [WIDTH-1:0]   add_z;
    logic               add_carry;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [WIDTH-1:0]   rsp_sum;
    logic               rsp_carry;
    logic               rsp_ready;
    logic               busy;

    modport slave (
        input  req_valid, req_x, req_y, add_z, add_carry, rsp_ready,
        output req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_sum,
        output rsp_carry, busy
    );

    modport master (
        output req_valid, req_x, req_y, add_z, add_carry, rsp_ready,
        input  req_ready, add_x, add_y, rsp_valid, rsp_id, rsp_sum,
        input  rsp_carry, busy
    );
endinterface

// File: rtl/adder_arbiter.sv
// Three requesters time-share one external adder: grant, add, respond.
// ADDER_ARB_FIXED_PRIORITY_EN selects fixed 0>1>2 priority instead of round-robin.
module adder_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ADD, RESP} state_e;

    state_e           state_q;
    logic [1:0]       id_q;
    logic [1:0]       win;
    logic [2:0]       gnt;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] add_x_q;
    logic [WIDTH-1:0] add_y_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_carry_q;
    logic             rsp_valid_q;
    logic [1:0]       rsp_id_q;
`ifndef ADDER_ARB_FIXED_PRIORITY_EN
    logic [1:0]       last_q;
    logic [2:0]       cand;
`endif

    always_comb begin
        gnt = 3'b000;
        win = 2'd0;
`ifdef ADDER_ARB_FIXED_PRIORITY_EN
        if (bus.req_valid[0]) begin
            gnt = 3'b001;
            win = 2'd0;
        end else if (bus.req_valid[1]) begin
            gnt = 3'b010;
            win = 2'd1;
        end else if (bus.req_valid[2]) begin
            gnt = 3'b100;
            win = 2'd2;
        end
`else
        cand = 3'd0;
        // Search starts just after the last winner and wraps modulo 3.
        for (int k = 1; k <= 3; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= 3'd3) cand = cand - 3'd3;
            if (gnt == 3'b000 && bus.req_valid[cand[1:0]]) begin
                gnt[cand[1:0]] = 1'b1;
                win = cand[1:0];
            end
        end
`endif
    end

    always_comb begin
        sel_x = bus.req_x[WIDTH-1:0];
        sel_y = bus.req_y[WIDTH-1:0];
        for (int i = 1; i < 3; i++) begin
            if (win == 2'(i)) begin
                sel_x = bus.req_x[i*WIDTH +: WIDTH];
                sel_y = bus.req_y[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            id_q        <= 2'd0;
            add_x_q     <= '0;
            add_y_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 2'd0;
`ifndef ADDER_ARB_FIXED_PRIORITY_EN
            last_q      <= 2'd2;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (gnt != 3'b000) begin
                        id_q    <= win;
                        add_x_q <= sel_x;
                        add_y_q <= sel_y;
`ifndef ADDER_ARB_FIXED_PRIORITY_EN
                        last_q  <= win;
`endif
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum_q   <= bus.add_z;
                    rsp_carry_q <= bus.add_carry;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Grant is combinational so the winner sees its pulse in the request cycle.
    assign bus.req_ready = (state_q == IDLE && rst_n) ? gnt : 3'b000;
    assign bus.busy      = (state_q != IDLE);
    assign bus.add_x     = add_x_q;
    assign bus.add_y     = add_y_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_carry = rsp_carry_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed literal cases plus a random run checked
// every cycle against a behavioural model of grant, latency and sum rules.
module tb_adder_arbiter;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   n_acc  = 0;

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // The external shared adder.
    assign {bus.add_carry, bus.add_z} = {1'b0, bus.add_x} + {1'b0, bus.add_y};

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [2:0] v, input logic [1:0] last);
`ifdef ADDER_ARB_FIXED_PRIORITY_EN
        for (int i = 0; i < 3; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= 3; k++)
            if (v[(int'(last) + k) % 3]) return (int'(last) + k) % 3;
`endif
        return -1;
    endfunction

    // Model: phase 0 free, 1 operands at the adder, 2 result offered.
    int         ph;
    logic [1:0] m_last, m_id, m_rid;
    logic [W-1:0] m_x, m_y, m_sum;
    logic       m_carry;

    always @(negedge clk) begin
        int w;
        logic [2:0] er;
        int tot;
        if (!rst_n) begin
            ph = 0; m_last = 2'd2; m_id = 0; m_rid = 0;
            m_x = 0; m_y = 0; m_sum = 0; m_carry = 0;
            chk("rst_req_ready", bus.req_ready, 0);
            chk("rst_rsp_valid", bus.rsp_valid, 0);
            chk("rst_rsp_id", bus.rsp_id, 0);
            chk("rst_rsp_sum", bus.rsp_sum, 0);
            chk("rst_rsp_carry", bus.rsp_carry, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_add_x", bus.add_x, 0);
            chk("rst_add_y", bus.add_y, 0);
        end else begin
            w  = pick(bus.req_valid, m_last);
            er = (ph == 0 && w >= 0) ? (3'b001 << w) : 3'b000;
            chk("req_ready", bus.req_ready, er);
            chk("busy", bus.busy, ph != 0);
            chk("rsp_valid", bus.rsp_valid, ph == 2);
            chk("rsp_id", bus.rsp_id, m_rid);
            chk("rsp_sum", bus.rsp_sum, m_sum);
            chk("rsp_carry", bus.rsp_carry, m_carry);
            if (ph == 1) begin
                chk("add_x", bus.add_x, m_x);
                chk("add_y", bus.add_y, m_y);
            end
            case (ph)
                0: if (w >= 0) begin
                    m_last = 2'(w);
                    m_id   = 2'(w);
                    m_x    = bus.req_x[w*W +: W];
                    m_y    = bus.req_y[w*W +: W];
                    n_acc++;
                    ph = 1;
                end
                1: begin
                    tot     = int'(m_x) + int'(m_y);
                    m_sum   = W'(tot % (1 << W));
                    m_carry = (tot >= (1 << W));
                    m_rid   = m_id;
                    ph = 2;
                end
                default: if (bus.rsp_ready) ph = 0;
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst_n = 1'b0;
        bus.req_valid = 3'b000;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0: return '1;
            1: return '0;
            2: return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    int         gcyc[$];
    logic [2:0] gval[$];
    logic [2:0] exp_rr[4];

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 3'b000;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.rsp_ready = 1'b1;
`ifdef ADDER_ARB_FIXED_PRIORITY_EN
        exp_rr = '{3'b001, 3'b001, 3'b001, 3'b001};
`else
        exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001};
`endif

        // Basic operation and latency.
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_x[W-1:0] = 16'h2AAB;
        bus.req_y[W-1:0] = 16'hD554;
        @(negedge clk);
        chk("d1_ready_c0", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        @(negedge clk);
        chk("d1_valid_c1", bus.rsp_valid, 0);
        cyc();
        @(negedge clk);
        chk("d1_valid_c2", bus.rsp_valid, 1);
        chk("d1_id", bus.rsp_id, 0);
        chk("d1_sum", bus.rsp_sum, 16'hFFFF);
        chk("d1_carry", bus.rsp_carry, 0);
        cyc();

        // All three requesting: grant order and spacing.
        do_reset();
        bus.req_valid = 3'b111;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.req_ready != 3'b000) begin
                gcyc.push_back(c);
                gval.push_back(bus.req_ready);
            end
            cyc();
        end
        bus.req_valid = 3'b000;
        chk("rr_count", gcyc.size(), 4);
        for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
            chk("rr_grant", gval[i], exp_rr[i]);
            chk("rr_cycle", gcyc[i], 3 * i);
        end

        // Overflow with back-pressure; requester 0 waits meanwhile.
        do_reset();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 3'b010;
        bus.req_x[W +: W] = 16'hFFFF;
        bus.req_y[W +: W] = 16'h0001;
        @(negedge clk);
        chk("d3_ready_c0", bus.req_ready, 3'b010);
        cyc();
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("d3_ready_c1", bus.req_ready, 3'b000);
        for (int j = 0; j < 5; j++) begin
            cyc();
            @(negedge clk);
            chk("d3_valid", bus.rsp_valid, 1);
            chk("d3_id", bus.rsp_id, 1);
            chk("d3_sum", bus.rsp_sum, 16'h0000);
            chk("d3_carry", bus.rsp_carry, 1);
            chk("d3_noready", bus.req_ready, 3'b000);
        end
        cyc();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("d3_noready_acc", bus.req_ready, 3'b000);
        cyc();
        @(negedge clk);
        chk("d3_ready_after", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        repeat (3) cyc();

        // Reset during ADD aborts the operation.
        do_reset();
        bus.req_valid = 3'b001;
        @(negedge clk);
        chk("d4_ready_c0", bus.req_ready, 3'b001);
        cyc();
        bus.req_valid = 3'b000;
        @(negedge clk);
        chk("d4_busy_add", bus.busy, 1);
        #2 rst_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("d4_no_valid", bus.rsp_valid, 0);
        cyc();
        rst_n = 1'b1;
        bus.req_valid = 3'b110;
        @(negedge clk);
        chk("d4_grant1", bus.req_ready, 3'b010);
        chk("d4_no_valid2", bus.rsp_valid, 0);
        cyc();
        bus.req_valid = 3'b000;
        repeat (3) cyc();

        // Random operation stream.
        do_reset();
        n_acc = 0;
        for (int c = 0; c < 80000 && n_acc < 10000; c++) begin
            bus.req_valid = 3'($urandom_range(0, 7));
            for (int i = 0; i < 3; i++) begin
                bus.req_x[i*W +: W] = rnd_op();
                bus.req_y[i*W +: W] = rnd_op();
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        chk("rand_ops_done", n_acc >= 10000, 1);
        bus.req_valid = 3'b000;
        bus.rsp_ready = 1'b1;
        repeat (5) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
